spi_frame_master: RTL

- SPI master that generates the 32-bit command frames consumed by the SPI slave / register-memory pair.
- Takes a packet from an upstream controller (packet loader or host FIFO) over a valid/ready handshake.
- Serialises the packet MSB-first on SCK/CS/MOSI.
- For read packets, extends the frame and captures the 12-bit read value returned on MISO.

---
 rtl/spi_frame_master_if.sv | 63 ++++++
 rtl/spi_frame_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master_if.sv
// ---------------------------------------------------------------------------
// spi_frame_master_if
//
// Bundles the upstream packet handshake, the SPI pins and the readback
// result of spi_frame_master into one port.
//
//   tx_data  [31:0]  packet {preamble, address, don't-care, value}
//   tx_valid         packet offered by the upstream controller
//   tx_ready         master can accept a packet (IDLE only)
//   SCK              SPI clock, idle low (mode 0)
//   CS               chip select, active low
//   MOSI             serial data to the slave, MSB first
//   MISO             serial data from the slave
//   rx_data          last captured read value
//   rx_valid         one-cycle pulse when rx_data updates
//   busy             high from packet accept until the inter-frame gap ends
//
// Modports:
//   master - the frame master itself
//   slave  - the environment: upstream controller plus the SPI slave
// ---------------------------------------------------------------------------
interface spi_frame_master_if #(
  parameter int RD_BITS = 12
);

  logic [31:0]        tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               SCK;
  logic               CS;
  logic               MOSI;
  logic               MISO;
  logic [RD_BITS-1:0] rx_data;
  logic               rx_valid;
  logic               busy;

  modport master (
    input  tx_data,
    input  tx_valid,
    input  MISO,
    output tx_ready,
    output SCK,
    output CS,
    output MOSI,
    output rx_data,
    output rx_valid,
    output busy
  );

  modport slave (
    output tx_data,
    output tx_valid,
    output MISO,
    input  tx_ready,
    input  SCK,
    input  CS,
    input  MOSI,
    input  rx_data,
    input  rx_valid,
    input  busy
  );

endinterface

// File: rtl/spi_frame_master.sv
// ---------------------------------------------------------------------------
// spi_frame_master
//
// SPI mode-0 master producing 32-bit command frames for the SPI slave /
// register-memory pair. A packet taken over the valid/ready handshake is
// shifted out MSB first. When the preamble marks a read, the frame is
// extended by RD_BITS clocks and the slave's reply is captured from MISO.
//
// Ports:
//   clk    - system clock, all logic on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - spi_frame_master_if.master: handshake, SPI pins, readback
//
// Frame timing (clk cycles):
//   CS low  = CS_SETUP + 2*CLK_DIV*N + CS_HOLD, N = 32 (+RD_BITS on read)
//   CS high = GAP cycles after the frame before tx_ready returns
// All SPI pins are registered, so they are glitch free.
// ---------------------------------------------------------------------------
module spi_frame_master #(
  parameter int         CLK_DIV     = 2,
  parameter int         CS_SETUP    = 2,
  parameter int         CS_HOLD     = 2,
  parameter int         GAP         = 4,
  parameter int         RD_BITS     = 12,
  parameter logic [7:0] RD_PREAMBLE = 8'hFA
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_frame_master_if.master bus
);

  // Counters reload with "length - 1" and the phase ends when they reach 0.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);
  localparam logic [7:0] WR_EDGES   = 8'd32;
  localparam logic [7:0] RD_EDGES   = 8'(32 + RD_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t             state_reg,    state_next;
  logic [7:0]         cnt_reg,      cnt_next;
  logic [7:0]         edge_cnt_reg, edge_cnt_next;
  // Bit 31 of the packet goes straight to MOSI on accept, so only the
  // remaining 31 bits need to be held for shifting.
  logic [30:0]        data_reg,     data_next;
  logic               is_read_reg,  is_read_next;
  logic [RD_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic [RD_BITS-1:0] rx_data_reg,  rx_data_next;
  logic               rx_valid_reg, rx_valid_next;
  logic               sck_reg,      sck_next;
  logic               cs_reg,       cs_next;
  logic               mosi_reg,     mosi_next;
  logic               tx_ready_reg, tx_ready_next;
  logic               busy_reg,     busy_next;

  logic [7:0]         frame_edges;

  assign frame_edges = is_read_reg ? RD_EDGES : WR_EDGES;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 8'd0;
      edge_cnt_reg <= 8'd0;
      data_reg     <= '0;
      is_read_reg  <= 1'b0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      sck_reg      <= 1'b0;
      cs_reg       <= 1'b1;
      mosi_reg     <= 1'b0;
      tx_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      edge_cnt_reg <= edge_cnt_next;
      data_reg     <= data_next;
      is_read_reg  <= is_read_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      sck_reg      <= sck_next;
      cs_reg       <= cs_next;
      mosi_reg     <= mosi_next;
      tx_ready_reg <= tx_ready_next;
      busy_reg     <= busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    edge_cnt_next = edge_cnt_reg;
    data_next     = data_reg;
    is_read_next  = is_read_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    sck_next      = sck_reg;
    cs_next       = cs_reg;
    mosi_next     = mosi_reg;
    tx_ready_next = tx_ready_reg;
    busy_next     = busy_reg;

    case (state_reg)
      ST_IDLE: begin
        cs_next       = 1'b1;
        sck_next      = 1'b0;
        busy_next     = 1'b0;
        tx_ready_next = 1'b1;
        // Accept uses the registered ready, so the first edge after reset
        // only raises tx_ready.
        if (bus.tx_valid && tx_ready_reg) begin
          state_next    = ST_SETUP;
          data_next     = bus.tx_data[30:0];
          is_read_next  = (bus.tx_data[31:24] == RD_PREAMBLE);
          mosi_next     = bus.tx_data[31];
          cs_next       = 1'b0;
          busy_next     = 1'b1;
          tx_ready_next = 1'b0;
          cnt_next      = SETUP_LAST;
          edge_cnt_next = 8'd0;
        end
      end

      ST_SETUP: begin
        if (cnt_reg == 8'd0) begin
          state_next    = ST_SHIFT;
          sck_next      = 1'b1;
          edge_cnt_next = 8'd1;
          cnt_next      = DIV_LAST;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else if (sck_reg) begin
          // Falling edge: present the next bit. Zeros shift in behind the
          // command, so MOSI idles low once bit 0 has been sent.
          sck_next  = 1'b0;
          mosi_next = data_reg[30];
          data_next = {data_reg[29:0], 1'b0};
          cnt_next  = DIV_LAST;
        end else if (edge_cnt_reg == frame_edges) begin
          // The last low half-period is completed before the hold time
          // starts, so every bit gets a full SCK period inside CS.
          state_next = ST_HOLD;
          cnt_next   = HOLD_LAST;
        end else begin
          sck_next      = 1'b1;
          edge_cnt_next = edge_cnt_reg + 8'd1;
          cnt_next      = DIV_LAST;
          // edge_cnt_reg counts rising edges already made; this edge is
          // number edge_cnt_reg+1, so readback starts at edge 33.
          if (is_read_reg && (edge_cnt_reg >= WR_EDGES)) begin
            rx_shift_next = {rx_shift_reg[RD_BITS-2:0], bus.MISO};
          end
        end
      end

      ST_HOLD: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_GAP;
          cs_next    = 1'b1;
          cnt_next   = GAP_LAST;
          if (is_read_reg) begin
            rx_data_next  = rx_shift_reg;
            rx_valid_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end

      ST_GAP: begin
        if (cnt_reg == 8'd0) begin
          state_next    = ST_IDLE;
          busy_next     = 1'b0;
          tx_ready_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.tx_ready = tx_ready_reg;
  assign bus.SCK      = sck_reg;
  assign bus.CS       = cs_reg;
  assign bus.MOSI     = mosi_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.busy     = busy_reg;

endmodule
